// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch, decode, execute,
// memory access and write-back, driving every datapath select and enable.
module mips_multicycle_ctrl (
  input  logic       Clk,
  input  logic       Reset_PC,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       Load_PC,
  output logic       Empty_PC,
  output logic       IRWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] Seletor_alu,
  output logic [1:0] PCSource,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_JUMP      = 4'd12,
    S_ILLEGAL   = 4'd13,
    S_SPARE14   = 4'd14,
    S_SPARE15   = 4'd15
  } state_t;

  typedef struct packed {
    logic       empty_pc;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic [1:0] pc_source;
    logic       pc_write;
    logic       pc_write_cond;
    logic       illegal;
  } ctrl_t;

  localparam logic [2:0] ALU_NOP = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t state;
  ctrl_t  ctrl;
  logic   is_store;   // lw/sw choice remembered from DECODE so MEM_ADDR needs no opcode

  // R-type funct -> ALU function; unsupported funct maps to nop
  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   r_alu = ALU_ADD;
      6'h22:   r_alu = ALU_SUB;
      6'h24:   r_alu = ALU_AND;
      6'h25:   r_alu = ALU_OR;
      6'h2A:   r_alu = ALU_SLT;
      default: r_alu = ALU_NOP;
    endcase
  endfunction

  // Next-state decode; opcode/funct only matter in DECODE
  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic [5:0] fn, input logic store);
    case (s)
      S_RESET:     next_state = S_FETCH;
      S_FETCH:     next_state = S_DECODE;
      S_DECODE: begin
        case (op)
          6'h00:         next_state = (r_alu(fn) != ALU_NOP) ? S_R_EXEC : S_ILLEGAL;
          6'h23, 6'h2B:  next_state = S_MEM_ADDR;
          6'h04:         next_state = S_BRANCH;
          6'h08:         next_state = S_ADDI_EXEC;
          6'h02:         next_state = S_JUMP;
          default:       next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  next_state = store ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  next_state = S_MEM_WB;
      S_R_EXEC:    next_state = S_R_WB;
      S_ADDI_EXEC: next_state = S_ADDI_WB;
      default:     next_state = S_FETCH;
    endcase
  endfunction

  // Moore output table for a given state
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.ir_write  = 1'b1;
        c.alu_src_b = 2'b01;
        c.alu_sel   = ALU_ADD;
        c.pc_write  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        c.alu_sel   = ALU_ADD;
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_sel   = ALU_ADD;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        c.mem_write = 1'b1;
        c.iord      = 1'b1;
      end
      S_R_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_sel   = r_alu(fn);
      end
      S_R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_sel       = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_sel   = ALU_ADD;
      end
      S_ADDI_WB:   c.reg_write = 1'b1;
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
      end
      S_ILLEGAL:   c.illegal = 1'b1;
      default:     c.empty_pc = 1'b1;
    endcase
    return c;
  endfunction

  // State register with outputs registered for the state being entered;
  // async reset loads RESET outputs at once, cancelling any pending write.
  always_ff @(posedge Clk or negedge Reset_PC) begin
    if (!Reset_PC) begin
      state    <= S_RESET;
      ctrl     <= ctrl_for(S_RESET, '0);
      is_store <= 1'b0;
    end else begin
      state <= next_state(state, Opcode, Funct, is_store);
      ctrl  <= ctrl_for(next_state(state, Opcode, Funct, is_store), Funct);
      if (state == S_DECODE)
        is_store <= (Opcode == 6'h2B);
    end
  end

  assign Load_PC     = ctrl.pc_write | (ctrl.pc_write_cond & Zero);
  assign Empty_PC    = ctrl.empty_pc;
  assign IRWrite     = ctrl.ir_write;
  assign MemRead     = ctrl.mem_read;
  assign MemWrite    = ctrl.mem_write;
  assign IorD        = ctrl.iord;
  assign RegWrite    = ctrl.reg_write;
  assign RegDst      = ctrl.reg_dst;
  assign MemtoReg    = ctrl.mem_to_reg;
  assign ALUSrcA     = ctrl.alu_src_a;
  assign ALUSrcB     = ctrl.alu_src_b;
  assign Seletor_alu = ctrl.alu_sel;
  assign PCSource    = ctrl.pc_source;
  assign Illegal     = ctrl.illegal;
  assign State       = state;

endmodule
